// File: rtl/ahb_bm_pkg.sv
// Shared definitions for the DMA bus matrix: AHB transfer/response encodings and the
// address/control bundle carried between stages.
package ahb_bm_pkg;

    localparam int unsigned AHB_ADDR_W = 32;
    localparam int unsigned AHB_PROT_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [AHB_PROT_W-1:0] prot;
    } ahb_addr_ctrl_t;

endpackage

// File: rtl/ahb_bm_hold_reg.sv
// Holding register for one AHB address phase; loads on request, clears on async reset.
module ahb_bm_hold_reg
    import ahb_bm_pkg::*;
(
    input  logic           HCLK,
    input  logic           HRESETn,
    input  logic           load,
    input  ahb_addr_ctrl_t d,
    output ahb_addr_ctrl_t q
);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ahb_input_stage_dma.sv
// DMA bus-matrix input stage: forwards the master's address phase to the decoder, or holds it
// and stalls the master while the targeted output stage is granting another input.
module ahb_input_stage_dma
    import ahb_bm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PROT_WIDTH = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSELS,
    input  logic [ADDR_WIDTH-1:0]  HADDRS,
    input  logic [1:0]             HTRANSS,
    input  logic                   HWRITES,
    input  logic [2:0]             HSIZES,
    input  logic [2:0]             HBURSTS,
    input  logic [PROT_WIDTH-1:0]  HPROTS,
    input  logic                   HREADYS,
    output logic                   HREADYOUTS,
    output logic [1:0]             HRESPS,
    output logic                   sel_dec,
    output logic [ADDR_WIDTH-11:0] decode_addr_dec,
    output logic [ADDR_WIDTH-1:0]  addr_dec,
    output logic [1:0]             trans_dec,
    output logic                   write_dec,
    output logic [2:0]             size_dec,
    output logic [2:0]             burst_dec,
    output logic [PROT_WIDTH-1:0]  prot_dec,
    output logic                   held_tran_dec,
    input  logic                   active_dec,
    input  logic                   readyout_dec,
    input  logic [1:0]             resp_dec
);

    logic           new_tran;
    logic           pend_reg;
    logic           pend_next;
    ahb_addr_ctrl_t hold_d;
    ahb_addr_ctrl_t hold_q;

    assign new_tran = HSELS & HTRANSS[1] & HREADYS;

    // A replayed transfer is always a fresh request to the decoder, so store it as NONSEQ.
    always_comb begin
        hold_d       = '0;
        hold_d.addr  = HADDRS;
        hold_d.trans = HTRANS_NONSEQ;
        hold_d.write = HWRITES;
        hold_d.size  = HSIZES;
        hold_d.burst = HBURSTS;
        hold_d.prot  = HPROTS;
    end

    ahb_bm_hold_reg u_hold_reg (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load    (new_tran),
        .d       (hold_d),
        .q       (hold_q)
    );

    // Set has priority: an accepted transfer implies HREADYS=1, i.e. any earlier hold is gone.
    always_comb begin
        pend_next = pend_reg;
        if (new_tran && !active_dec) begin
            pend_next = 1'b1;
        end else if (pend_reg && active_dec && readyout_dec) begin
            pend_next = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    always_comb begin
        sel_dec       = HSELS;
        addr_dec      = HADDRS;
        trans_dec     = HTRANSS;
        write_dec     = HWRITES;
        size_dec      = HSIZES;
        burst_dec     = HBURSTS;
        prot_dec      = HPROTS;
        held_tran_dec = 1'b0;
        HREADYOUTS    = readyout_dec;
        HRESPS        = resp_dec;
        if (pend_reg) begin
            sel_dec       = 1'b1;
            addr_dec      = hold_q.addr;
            trans_dec     = hold_q.trans;
            write_dec     = hold_q.write;
            size_dec      = hold_q.size;
            burst_dec     = hold_q.burst;
            prot_dec      = hold_q.prot;
            held_tran_dec = 1'b1;
            HREADYOUTS    = 1'b0;
            HRESPS        = HRESP_OKAY;
        end
    end

    assign decode_addr_dec = addr_dec[ADDR_WIDTH-1:10];

endmodule

// File: tb/tb_ahb_input_stage_dma.sv
// Scoreboard bench for ahb_input_stage_dma: directed scenarios plus randomized traffic.
module tb_ahb_input_stage_dma;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_dec;
    logic [21:0] decode_addr_dec;
    logic [31:0] addr_dec;
    logic [1:0]  trans_dec;
    logic        write_dec;
    logic [2:0]  size_dec;
    logic [2:0]  burst_dec;
    logic [3:0]  prot_dec;
    logic        held_tran_dec;
    logic        active_dec;
    logic        readyout_dec;
    logic [1:0]  resp_dec;

    ahb_input_stage_dma #(
        .ADDR_WIDTH (32),
        .PROT_WIDTH (4)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .HSELS           (HSELS),
        .HADDRS          (HADDRS),
        .HTRANSS         (HTRANSS),
        .HWRITES         (HWRITES),
        .HSIZES          (HSIZES),
        .HBURSTS         (HBURSTS),
        .HPROTS          (HPROTS),
        .HREADYS         (HREADYS),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .addr_dec        (addr_dec),
        .trans_dec       (trans_dec),
        .write_dec       (write_dec),
        .size_dec        (size_dec),
        .burst_dec       (burst_dec),
        .prot_dec        (prot_dec),
        .held_tran_dec   (held_tran_dec),
        .active_dec      (active_dec),
        .readyout_dec    (readyout_dec),
        .resp_dec        (resp_dec)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  sz;
        logic [2:0]  bu;
        logic [3:0]  pr;
        logic        held;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   mon_en = 1'b0;
    bit   stalled = 1'b0;     // model: a transfer is parked and the master is waiting
    bit   stalled_nxt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One bus cycle: drive inputs just after the edge and advance the reference model.
    task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] sz, input logic [2:0] bu,
                        input logic [3:0] pr, input logic act, input logic rdy,
                        input logic [1:0] rsp);
        logic acc;
        exp_t e;
        @(posedge HCLK);
        stalled = stalled_nxt;
        #1;
        HSELS = sel; HTRANSS = tr; HADDRS = a; HWRITES = wr;
        HSIZES = sz; HBURSTS = bu; HPROTS = pr;
        active_dec = act; readyout_dec = rdy; resp_dec = rsp;
        HREADYS = stalled ? 1'b0 : rdy;
        acc = sel & tr[1] & HREADYS;
        if (!stalled && acc) begin
            e.addr = a; e.wr = wr; e.sz = sz; e.bu = bu; e.pr = pr;
            e.held = !act;
            e.trans = act ? tr : 2'b10;
            exp_q.push_back(e);
            pushed++;
        end
        stalled_nxt = stalled ? !(act && rdy) : (acc && !act);
    endtask

    task automatic idle(input logic act, input logic rdy);
        step(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 4'd0, act, rdy, 2'b00);
    endtask

    // Monitor: per-cycle response model, and a scoreboard pop whenever the decoder takes an
    // address phase from this input.
    always @(negedge HCLK) begin
        if (mon_en && HRESETn) begin
            exp_t e;
            chk("hreadyout", HREADYOUTS, stalled ? 1'b0 : readyout_dec);
            chk("hresp", HRESPS, stalled ? 2'b00 : resp_dec);
            chk("held_flag", held_tran_dec, stalled);
            if (sel_dec && trans_dec[1] && active_dec &&
                (held_tran_dec ? readyout_dec : HREADYS)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", addr_dec, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    chk("addr", addr_dec, e.addr);
                    chk("decode_addr", decode_addr_dec, e.addr >> 10);
                    chk("trans", trans_dec, e.trans);
                    chk("ctrl", {write_dec, size_dec, burst_dec, prot_dec},
                        {e.wr, e.sz, e.bu, e.pr});
                    chk("xfer_held", held_tran_dec, e.held);
                end
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HSIZES = 0; HBURSTS = 0; HPROTS = 0;
        HREADYS = 1; active_dec = 0; readyout_dec = 1; resp_dec = 0;
        #3;
        chk("rst_hreadyout", HREADYOUTS, 1'b1);
        chk("rst_hresp", HRESPS, 2'b00);
        chk("rst_held", held_tran_dec, 1'b0);
        chk("rst_trans", trans_dec, 2'b00);
        chk("rst_sel", sel_dec, 1'b0);
        repeat (2) @(negedge HCLK);
        #1 HRESETn = 1'b1;
        mon_en = 1'b1;

        // Pass-through, zero latency
        step(1'b1, 2'b10, 32'h2000_0010, 1'b0, 3'd2, 3'd0, 4'd3, 1'b1, 1'b1, 2'b00);
        @(negedge HCLK);
        chk("pt_decode_addr", decode_addr_dec, 22'h080000);

        // Hold while the output stage is busy; later address changes must be ignored
        step(1'b1, 2'b10, 32'h4001_0004, 1'b1, 3'd2, 3'd1, 4'd5, 1'b0, 1'b1, 2'b00);
        step(1'b1, 2'b10, 32'hDEAD_BEE0, 1'b0, 3'd0, 3'd3, 4'd1, 1'b0, 1'b1, 2'b00);
        @(negedge HCLK);
        chk("hold_addr", addr_dec, 32'h4001_0004);
        chk("hold_ready", HREADYOUTS, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // SEQ captured while held is replayed as NONSEQ
        step(1'b1, 2'b11, 32'h4001_0008, 1'b0, 3'd2, 3'd1, 4'd2, 1'b0, 1'b1, 2'b00);
        idle(1'b0, 1'b1);
        @(negedge HCLK);
        chk("held_seq_trans", trans_dec, 2'b10);
        idle(1'b1, 1'b1);

        // Two-cycle ERROR, master goes IDLE in the second cycle
        step(1'b1, 2'b10, 32'h0000_1234, 1'b0, 3'd2, 3'd0, 4'd0, 1'b1, 1'b0, 2'b01);
        step(1'b1, 2'b00, 32'h0000_5678, 1'b0, 3'd2, 3'd0, 4'd0, 1'b1, 1'b1, 2'b01);
        @(negedge HCLK);
        chk("err_resp2", HRESPS, 2'b01);
        idle(1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       rdy;
            logic [1:0] rsp;
            rdy = ($urandom_range(0, 3) != 0);
            rsp = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 1'($urandom),
                 3'($urandom), 3'($urandom), 4'($urandom), $urandom_range(0, 2) != 0,
                 rdy, rsp);
        end
        repeat (3) idle(1'b1, 1'b1);

        // Asynchronous reset while a transfer is held
        step(1'b1, 2'b10, 32'h5555_0000, 1'b1, 3'd1, 3'd0, 4'd0, 1'b0, 1'b1, 2'b00);
        @(posedge HCLK);
        #2;
        mon_en = 1'b0;
        chk("pre_rst_held", held_tran_dec, 1'b1);
        HRESETn = 1'b0;
        HSELS = 1'b0; HTRANSS = 2'b00; readyout_dec = 1'b1; resp_dec = 2'b00;
        #1;
        chk("arst_held", held_tran_dec, 1'b0);
        chk("arst_hreadyout", HREADYOUTS, 1'b1);
        exp_q.delete();
        pushed--;
        stalled = 1'b0;
        stalled_nxt = 1'b0;
        @(negedge HCLK);
        #1 HRESETn = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 1'($urandom),
                 3'($urandom), 3'($urandom), 4'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, 2'b00);
        end
        repeat (3) idle(1'b1, 1'b1);
        @(negedge HCLK);
        chk("sb_empty", exp_q.size(), 0);
        chk("sb_count", popped, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
